// File: rtl/tm1638_key_events.sv
// Debounces the TM1638 key vector and queues stable key transitions as events.
// Optional macro TM1638_KEY_EVENTS_RELEASE_EN: also queue release events.

module tm1638_key_events #(
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [7:0] keys,
   output logic [7:0] keys_stable,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [2:0] ev_key,
   output logic       ev_press,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam int unsigned NUM_KEYS = 8;
   localparam int unsigned CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W1   = PTR_W + 1;

   logic [7:0]       sync_q;
   logic [7:0]       ks_q;
   logic [7:0]       stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [NUM_KEYS];
   logic [CNT_W-1:0] cnt_d [NUM_KEYS];
   logic [7:0]       pend_q, pend_d;
   logic [7:0]       pend_set, pend_clr;
   logic             scan_push;
   logic [2:0]       scan_sel;
   logic [PTR_W:0]   wr_q, wr_d;
   logic [PTR_W:0]   rd_q, rd_d;
   logic [2:0]       key_mem_q [FIFO_DEPTH];
   logic             fifo_empty, fifo_full;
   logic             pop, push_ok, drop;
   logic             ovf_q, ovf_d;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
   logic [7:0]            pol_q, pol_d;
   logic [FIFO_DEPTH-1:0] press_mem_q;
`endif

   // Per-key debounce: count consecutive ticks that disagree with the stable state
   always_comb begin
      stable_d = stable_q;
      pend_set = '0;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
      pol_d    = pol_q;
`endif
      for (int i = 0; i < NUM_KEYS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (ks_q[i] == stable_q[i]) begin
               cnt_d[i] = '0;
            end else if ((cnt_q[i] + CNT_W'(1)) == CNT_W'(DEBOUNCE_TICKS)) begin
               stable_d[i] = ~stable_q[i];
               cnt_d[i]    = '0;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
               pend_set[i] = 1'b1;
               pol_d[i]    = ~stable_q[i];
`else
               pend_set[i] = ~stable_q[i];
`endif
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Scanner: lowest pending key wins, one push per clock
   always_comb begin
      scan_sel = '0;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i]) scan_sel = 3'(i);
      end
      scan_push = |pend_q;
      pend_clr  = scan_push ? (8'b1 << scan_sel) : 8'b0;
      pend_d    = (pend_q & ~pend_clr) | pend_set;
   end

   // FIFO occupancy via an extra pointer bit; a full FIFO still accepts a push alongside a pop
   assign fifo_empty = (wr_q == rd_q);
   assign fifo_full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                       (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign pop        = !fifo_empty && ev_ready;
   assign push_ok    = scan_push && (!fifo_full || pop);
   assign drop       = scan_push && fifo_full && !pop;
   assign wr_d       = push_ok ? (wr_q + PTR_W1'(1)) : wr_q;
   assign rd_d       = pop ? (rd_q + PTR_W1'(1)) : rd_q;
   assign ovf_d      = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

   assign keys_stable = stable_q;
   assign ev_valid    = !fifo_empty;
   assign ev_key      = key_mem_q[rd_q[PTR_W-1:0]];
   assign overflow    = ovf_q;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
   assign ev_press    = press_mem_q[rd_q[PTR_W-1:0]];
`else
   assign ev_press    = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         ks_q     <= '0;
         stable_q <= '0;
         pend_q   <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
         for (int unsigned d = 0; d < FIFO_DEPTH; d++) key_mem_q[d] <= '0;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
         pol_q       <= '0;
         press_mem_q <= '0;
`endif
      end else begin
         sync_q   <= keys;
         ks_q     <= sync_q;
         stable_q <= stable_d;
         pend_q   <= pend_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         ovf_q    <= ovf_d;
         for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
         pol_q <= pol_d;
`endif
         if (push_ok) begin
            key_mem_q[wr_q[PTR_W-1:0]] <= scan_sel;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
            press_mem_q[wr_q[PTR_W-1:0]] <= pol_q[scan_sel];
`endif
         end
      end
   end

endmodule

// File: tb/tb_tm1638_key_events.sv
// Self-checking bench for tm1638_key_events against a tick-level event model.

module tb_tm1638_key_events;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;
`ifdef TM1638_KEY_EVENTS_RELEASE_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, tick, ev_ready, ovf_clr;
   logic [7:0] keys;
   logic [7:0] keys_stable;
   logic       ev_valid, ev_press, overflow;
   logic [2:0] ev_key;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] obs_v, exp_v;
   int          obs_n, exp_n;

   // Reference model: stable state, disagree-run length, queued events {press,key}
   bit [7:0] m_stable;
   int       m_cnt [8];
   bit [3:0] m_q [$];
   bit       m_ovf;

   tm1638_key_events #(.DEBOUNCE_TICKS(DEB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .tick(tick), .keys(keys),
      .keys_stable(keys_stable), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_key(ev_key), .ev_press(ev_press), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_stable = '0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_q.delete();
      m_ovf = 1'b0;
   endfunction

   // One tick: a key flips after DEB consecutive disagreeing samples; events enqueue in key order
   function automatic void model_tick(input logic [7:0] k);
      for (int i = 0; i < 8; i++) begin
         if (k[i] == m_stable[i]) m_cnt[i] = 0;
         else begin
            m_cnt[i]++;
            if (m_cnt[i] == DEB) begin
               m_stable[i] = ~m_stable[i];
               m_cnt[i] = 0;
               if (REL || m_stable[i]) begin
                  if (m_q.size() < DEPTH) m_q.push_back({m_stable[i], 3'(i)});
                  else m_ovf = 1'b1;
               end
            end
         end
      end
   endfunction

   function automatic logic [63:0] pack_model();
      logic [63:0] v = '0;
      foreach (m_q[i]) v = (v << 4) | 64'(m_q[i]);
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Returns 1ns after the edge that samples the tick
   task automatic do_tick();
      idle(3);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      model_tick(keys);
   endtask

   task automatic hold(input logic [7:0] k, input int n);
      keys = k;
      repeat (n) begin do_tick(); idle(9); end
   endtask

   // Pops everything currently queued, recording events in order
   task automatic drain(output logic [63:0] v, output int n);
      v = '0; n = 0;
      ev_ready = 1'b1;
      for (int c = 0; c < 2 * DEPTH + 4 && ev_valid === 1'b1; c++) begin
         v = (v << 4) | 64'({ev_press, ev_key});
         n++;
         @(posedge clk); #1;
      end
      ev_ready = 1'b0;
   endtask

   task automatic model_drain();
      exp_v = pack_model();
      exp_n = m_q.size();
      m_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(2); rst = 1'b0;
      model_reset();
      n_checks++; if (keys_stable !== 8'h00) begin n_fail++; $display("FAIL reset_stable: got %h want 00", keys_stable); end
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
      n_checks++; if (ev_key !== 3'd0) begin n_fail++; $display("FAIL reset_key: got %0d want 0", ev_key); end
      n_checks++; if (ev_press !== !REL) begin n_fail++; $display("FAIL reset_press: got %b want %b", ev_press, !REL); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_single_press();
      keys = 8'h01;
      repeat (3) begin
         do_tick();
         n_checks++; if (keys_stable !== m_stable) begin n_fail++; $display("FAIL single_early: got %h want %h", keys_stable, m_stable); end
         idle(9);
      end
      do_tick();
      n_checks++; if (keys_stable !== 8'h01) begin n_fail++; $display("FAIL single_stable: got %h want 01", keys_stable); end
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_nobypass: got %b want 0", ev_valid); end
      idle(1);
      n_checks++; if ({ev_valid, ev_press, ev_key} !== 5'b11_000) begin n_fail++; $display("FAIL single_event: got v%b p%b k%0d want v1 p1 k0", ev_valid, ev_press, ev_key); end
      ev_ready = 1'b1; idle(1); ev_ready = 1'b0;
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b want 0", ev_valid); end
      m_q.delete();
      idle(8);
   endtask

   task automatic test_glitch();
      hold(8'h81, 3); hold(8'h01, 1); hold(8'h81, 3); hold(8'h01, 1);
      n_checks++; if (keys_stable !== 8'h01) begin n_fail++; $display("FAIL glitch_stable: got %h want 01", keys_stable); end
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", ev_valid); end
   endtask

   task automatic test_simultaneous();
      hold(8'h00, 4);
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL sim_rel0: got %0d ev %h want %0d ev %h", obs_n, obs_v, exp_n, exp_v); end
      hold(8'h29, 4);
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== 64'h8BD || obs_n != 3) begin n_fail++; $display("FAIL sim_order: got %0d ev %h want 3 ev 8bd", obs_n, obs_v); end
      n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL sim_model: got %0d ev %h want %0d ev %h", obs_n, obs_v, exp_n, exp_v); end
      hold(8'h00, 4);
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL sim_release: got %0d ev %h want %0d ev %h", obs_n, obs_v, exp_n, exp_v); end
      // Stream with ev_ready high: consecutive pushes overlap with pops
      keys = 8'h29;
      repeat (3) begin do_tick(); idle(9); end
      do_tick();
      idle(1);
      n_checks++; if ({ev_valid, ev_key} !== 4'b1_000) begin n_fail++; $display("FAIL stream_0: got v%b k%0d want v1 k0", ev_valid, ev_key); end
      ev_ready = 1'b1;
      idle(1);
      n_checks++; if ({ev_valid, ev_key} !== 4'b1_011) begin n_fail++; $display("FAIL stream_3: got v%b k%0d want v1 k3", ev_valid, ev_key); end
      idle(1);
      n_checks++; if ({ev_valid, ev_key} !== 4'b1_101) begin n_fail++; $display("FAIL stream_5: got v%b k%0d want v1 k5", ev_valid, ev_key); end
      idle(1);
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b want 0", ev_valid); end
      ev_ready = 1'b0;
      m_q.delete();
      idle(5);
   endtask

   task automatic test_overflow();
      hold(8'h00, 4);
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL ovf_pre: got %0d ev %h want %0d ev %h", obs_n, obs_v, exp_n, exp_v); end
      hold(8'h3F, 4);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== 64'h89AB || obs_n != 4) begin n_fail++; $display("FAIL ovf_kept: got %0d ev %h want 4 ev 89ab", obs_n, obs_v); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0; m_ovf = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
   endtask

   task automatic test_ovf_set_wins();
      hold(8'h00, 4);
      drain(obs_v, obs_n); m_q.delete();
      ovf_clr = 1'b1; idle(1); m_ovf = 1'b0;
      keys = 8'h1F;
      repeat (3) begin do_tick(); idle(9); end
      do_tick();
      idle(4);
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL setwins_before: got %b want 0", overflow); end
      idle(1);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL setwins_drop: got %b want 1", overflow); end
      ovf_clr = 1'b0;
      idle(1);
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL setwins_after: got %b want %b", overflow, m_ovf); end
      idle(3);
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL setwins_q: got %0d ev %h want %0d ev %h", obs_n, obs_v, exp_n, exp_v); end
      ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic test_release();
      hold(8'h1B, 4);
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== (REL ? 64'h2 : 64'h0) || obs_n != (REL ? 1 : 0)) begin n_fail++; $display("FAIL release_k2: got %0d ev %h want %0d ev %h", obs_n, obs_v, REL ? 1 : 0, REL ? 2 : 0); end
      n_checks++; if (keys_stable !== 8'h1B) begin n_fail++; $display("FAIL release_stable: got %h want 1b", keys_stable); end
   endtask

   task automatic test_reset_mid();
      hold(8'h3F, 4);
      n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_queued: got %b want 1", ev_valid); end
      rst = 1'b1; idle(1); rst = 1'b0;
      model_reset();
      n_checks++; if ({ev_valid, overflow} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flush: got v%b o%b want v0 o0", ev_valid, overflow); end
      n_checks++; if (keys_stable !== 8'h00) begin n_fail++; $display("FAIL rstmid_stable: got %h want 00", keys_stable); end
      keys = 8'h3F;
      repeat (3) begin do_tick(); idle(9); end
      n_checks++; if (keys_stable !== 8'h00) begin n_fail++; $display("FAIL rstmid_early: got %h want 00", keys_stable); end
      do_tick(); idle(9);
      n_checks++; if (keys_stable !== 8'h3F || overflow !== m_ovf) begin n_fail++; $display("FAIL rstmid_repress: got %h o%b want 3f o%b", keys_stable, overflow, m_ovf); end
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== 64'h89AB || obs_n != 4) begin n_fail++; $display("FAIL rstmid_q: got %0d ev %h want 4 ev 89ab", obs_n, obs_v); end
      ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         keys = 8'($urandom);
         repeat ($urandom_range(1, 6)) begin
            do_tick();
            n_checks++; if (keys_stable !== m_stable) begin n_fail++; $display("FAIL rnd_stable it%0d: got %h want %h", it, keys_stable, m_stable); end
            idle(9);
         end
         n_checks++; if (ev_valid !== (m_q.size() != 0) || overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_flags it%0d: got v%b o%b want v%b o%b", it, ev_valid, overflow, m_q.size() != 0, m_ovf); end
         if ($urandom_range(0, 1) == 1) begin
            drain(obs_v, obs_n); model_drain();
            n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL rnd_q it%0d: got %0d ev %h want %0d ev %h", it, obs_n, obs_v, exp_n, exp_v); end
         end
         if ($urandom_range(0, 3) == 0) begin
            ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0; m_ovf = 1'b0;
         end
      end
      drain(obs_v, obs_n); model_drain();
      n_checks++; if (obs_v !== exp_v || obs_n != exp_n) begin n_fail++; $display("FAIL rnd_final: got %0d ev %h want %0d ev %h", obs_n, obs_v, exp_n, exp_v); end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; keys = 8'h00; ev_ready = 1'b0; ovf_clr = 1'b0;
      model_reset();
      @(posedge clk); #1;
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_overflow();
      test_ovf_set_wins();
      test_release();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
